// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - RF transceiver instruction/state types shared by the access arbiter
package rf_pkg;

    localparam int RF_ADDR_W = 10;
    localparam int RF_DATA_W = 8;

    typedef enum logic [1:0] {
        RF_SHORT_RD = 2'b00,
        RF_SHORT_WR = 2'b01,
        RF_LONG_RD  = 2'b10,
        RF_LONG_WR  = 2'b11
    } rf_inst_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        SETTLE,
        WAIT
    } rf_arb_state_t;

    function automatic logic rf_is_read(input rf_inst_t inst);
        return (inst == RF_SHORT_RD) || (inst == RF_LONG_RD);
    endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// rtl/rf_rr_pick.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module rf_rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
                valid_o                             = 1'b1;
                gnt_o[(int'(ptr_i) + k) % NREQ]     = 1'b1;
                idx_o                               = PW'((int'(ptr_i) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// rtl/rf_access_arbiter.sv - round-robin sharing of the RF transceiver handshake; RF_ARB_TIMEOUT_EN adds a ready watchdog
module rf_access_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int SETUP_CYC   = 2,
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_i,
    input  logic [2*NREQ-1:0]           req_inst_i,
    input  logic [RF_ADDR_W*NREQ-1:0]   req_addr_i,
    input  logic [RF_DATA_W*NREQ-1:0]   req_wdata_i,
    output logic [NREQ-1:0]             gnt_o,
    output logic [NREQ-1:0]             done_o,
    output logic [NREQ-1:0]             err_o,
    output logic [RF_DATA_W-1:0]        rdata_o,
    input  logic                        rf_ready_i,
    input  logic [RF_DATA_W-1:0]        rf_rdata_i,
    output logic [RF_ADDR_W-1:0]        rf_addr_o,
    output logic [RF_DATA_W-1:0]        rf_data_o,
    output logic [1:0]                  rf_inst_o,
    output logic                        rf_cs_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 8;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("rf_access_arbiter: parameter out of range");
    end

    rf_arb_state_t          state_q;
    logic [CW-1:0]          cnt_q;
    logic [PW-1:0]          ptr_q, gidx_q, ptr_d;
    logic [NREQ-1:0]        gnt_q, done_q;
    logic [RF_DATA_W-1:0]   rdata_q, rf_data_q;
    logic [RF_ADDR_W-1:0]   rf_addr_q;
    rf_inst_t               rf_inst_q;
    logic                   rf_cs_q;

    logic [NREQ-1:0]        pick_gnt_d;
    logic [PW-1:0]          pick_idx_d;
    logic                   pick_vld_d;
    logic [RF_ADDR_W-1:0]   sel_addr_d;
    logic [RF_DATA_W-1:0]   sel_wdata_d;
    logic [1:0]             sel_inst_d;

    // The requester just served still holds req during its done cycle; that level is not a new request.
    rf_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i   (req_i & ~done_q),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt_d),
        .idx_o   (pick_idx_d),
        .valid_o (pick_vld_d)
    );

    always_comb begin
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        sel_inst_d  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt_d[i]) begin
                sel_addr_d  = req_addr_i[i*RF_ADDR_W +: RF_ADDR_W];
                sel_wdata_d = req_wdata_i[i*RF_DATA_W +: RF_DATA_W];
                sel_inst_d  = req_inst_i[2*i +: 2];
            end
        end
    end

    assign ptr_d = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);

`ifdef RF_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic [NREQ-1:0] err_q;
    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gidx_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            rf_inst_q <= RF_SHORT_RD;
            rf_cs_q   <= 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= '0;
`endif
        end else begin
            done_q  <= '0;
            rf_cs_q <= 1'b0;
`ifdef RF_ARB_TIMEOUT_EN
            err_q   <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        gnt_q     <= pick_gnt_d;
                        gidx_q    <= pick_idx_d;
                        rf_addr_q <= sel_addr_d;
                        rf_data_q <= sel_wdata_d;
                        rf_inst_q <= rf_inst_t'(sel_inst_d);
                        cnt_q     <= '0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == CW'(SETUP_CYC - 1)) begin
                        cnt_q   <= '0;
                        rf_cs_q <= 1'b1;
                        state_q <= STROBE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STROBE: state_q <= SETTLE;
                SETTLE: begin
                    // RF drops ready some time after the strobe, so ready is not trusted yet.
                    if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
`ifdef RF_ARB_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT: begin
                    if (rf_ready_i) begin
                        if (rf_is_read(rf_inst_q)) rdata_q <= rf_rdata_i;
                        done_q  <= gnt_q;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
`ifdef RF_ARB_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        rdata_q <= '0;
                        done_q  <= gnt_q;
                        err_q   <= gnt_q;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign rf_addr_o = rf_addr_q;
    assign rf_data_o = rf_data_q;
    assign rf_inst_o = rf_inst_q;
    assign rf_cs_o   = rf_cs_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb/tb_rf_access_arbiter.sv - bench for rf_access_arbiter; honours RF_ARB_TIMEOUT_EN
module tb_rf_access_arbiter;

    localparam int N  = 3;
    localparam int S  = 2;
    localparam int T  = 3;
    localparam int TO = 4096;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req;
    logic [2*N-1:0] req_inst;
    logic [10*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   gnt_o, done_o, err_o;
    logic [7:0]     rdata_o;
    logic           rf_ready;
    logic [7:0]     rf_rdata;
    logic [9:0]     rf_addr_o;
    logic [7:0]     rf_data_o;
    logic [1:0]     rf_inst_o;
    logic           rf_cs_o;

    always #5 clk = ~clk;

    rf_access_arbiter #(.NREQ(N), .SETUP_CYC(S), .SETTLE_CYC(T), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req), .req_inst_i(req_inst), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .rf_ready_i(rf_ready), .rf_rdata_i(rf_rdata), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
        .rf_inst_o(rf_inst_o), .rf_cs_o(rf_cs_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         resp_delay = 5;
    int         resp_cnt   = 0;
    bit         hang = 1'b0;
    bit         hold = 1'b0;
    logic [7:0] resp_data = 8'h00;

    // Transaction-level model: busy flag, age since grant, round-robin pointer.
    bit         m_busy = 1'b0;
    int         m_g = 0, m_age = 0, m_ptr = 0;
    logic [9:0] m_addr;
    logic [7:0] m_data;
    logic [1:0] m_inst;
    logic [N-1:0] m_done = '0, m_err = '0;
    logic [7:0] m_rdata = 8'h00;

    int         gq[$];
    int         cs_cyc[$];
    int         done_cnt[N];
    int         done_cyc = 0, gnt_cyc = 0;
    logic [N-1:0] last_err;
    logic [9:0] cs_addr;
    logic [7:0] cs_data;
    logic [1:0] cs_inst;
    logic [N-1:0] prev_gnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic set_slot(input int i, input logic [1:0] inst, input logic [9:0] addr, input logic [7:0] wd);
        req_inst[2*i +: 2]   = inst;
        req_addr[10*i +: 10] = addr;
        req_wdata[8*i +: 8]  = wd;
    endtask

    task automatic wait_done(input int i, input int target, input int limit);
        for (int k = 0; k < limit && done_cnt[i] < target; k++) begin
            @(negedge clk); #1;
        end
        chk("wait_done", done_cnt[i], target);
    endtask

    task automatic wait_grants(input int target, input int limit);
        for (int k = 0; k < limit && gq.size() < target; k++) begin
            @(negedge clk); #1;
        end
        chk("wait_grants", gq.size(), target);
    endtask

    task automatic wait_cs(input int target, input int limit);
        for (int k = 0; k < limit && cs_cyc.size() < target; k++) begin
            @(negedge clk); #1;
        end
        chk("wait_cs", cs_cyc.size(), target);
    endtask

    // RF responder: drops ready on the strobe, raises it with read data resp_delay cycles later.
    initial forever begin
        @(posedge clk); #2;
        if (rf_cs_o) begin
            rf_ready = 1'b0;
            resp_cnt = resp_delay;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0 && !hang) begin
                rf_ready = 1'b1;
                rf_rdata = resp_data;
            end
        end
    end

    // Requesters release req once they see their done pulse.
    initial forever begin
        @(posedge clk); #1;
        if (!hold) req = req & ~done_o;
    end

    initial forever begin
        logic [N-1:0] nd, ne, elig;
        int j;
        @(negedge clk);
        cyc++;
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_done = '0; m_err = '0; m_rdata = 8'h00;
            chk("rst_gnt", gnt_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_rdata", rdata_o, 0);
            chk("rst_cs", rf_cs_o, 0);
            chk("rst_addr", rf_addr_o, 0);
            chk("rst_data", rf_data_o, 0);
            chk("rst_inst", rf_inst_o, 0);
        end else begin
            chk("gnt", gnt_o, m_busy ? (1 << m_g) : 0);
            chk("done", done_o, m_done);
            chk("err", err_o, m_err);
            chk("rdata", rdata_o, m_rdata);
            chk("rf_cs", rf_cs_o, (m_busy && m_age == S) ? 1 : 0);
            if (m_busy) begin
                chk("rf_addr", rf_addr_o, m_addr);
                chk("rf_data", rf_data_o, m_data);
                chk("rf_inst", rf_inst_o, m_inst);
            end
            if (rf_cs_o) begin
                cs_cyc.push_back(cyc);
                cs_addr = rf_addr_o; cs_data = rf_data_o; cs_inst = rf_inst_o;
            end
            for (int i = 0; i < N; i++) begin
                if (done_o[i]) begin
                    done_cnt[i]++;
                    done_cyc = cyc;
                    last_err = err_o;
                end
            end
            if (gnt_o != 0 && prev_gnt == 0) begin
                gnt_cyc = cyc;
                for (int i = 0; i < N; i++) if (gnt_o[i]) gq.push_back(i);
            end
            nd = '0;
            ne = '0;
            if (m_busy) begin
                if (m_age >= S + T + 1 && rf_ready) begin
                    nd[m_g] = 1'b1;
                    if (m_inst[0] == 1'b0) m_rdata = rf_rdata;
                    m_ptr  = (m_g + 1) % N;
                    m_busy = 1'b0;
                end
`ifdef RF_ARB_TIMEOUT_EN
                else if (m_age == S + T + TO) begin
                    nd[m_g] = 1'b1;
                    ne[m_g] = 1'b1;
                    m_rdata = 8'h00;
                    m_ptr   = (m_g + 1) % N;
                    m_busy  = 1'b0;
                end
`endif
                else m_age++;
            end else begin
                elig = req & ~m_done;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!m_busy && elig[j]) begin
                        m_busy = 1'b1; m_g = j; m_age = 0;
                        m_addr = req_addr[10*j +: 10];
                        m_data = req_wdata[8*j +: 8];
                        m_inst = req_inst[2*j +: 2];
                    end
                end
            end
            m_done = nd;
            m_err  = ne;
        end
        prev_gnt = gnt_o;
    end

    initial begin
        int treq, g0, n, d0, d1;
        req = '0; req_inst = '0; req_addr = '0; req_wdata = '0;
        rf_ready = 1'b1; rf_rdata = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // single short write from requester 0
        @(posedge clk); #3;
        set_slot(0, 2'b01, 10'h031, 8'hA5);
        req[0] = 1'b1;
        treq = cyc + 1;
        wait_done(0, 1, 40);
        chk("A_cs_count", cs_cyc.size(), 1);
        chk("A_cs_lat", cs_cyc[0] - treq, 3);
        chk("A_cs_addr", cs_addr, 10'h031);
        chk("A_cs_data", cs_data, 8'hA5);
        chk("A_cs_inst", cs_inst, 2'b01);
        chk("A_done_lat", done_cyc - treq, 9);
        repeat (5) @(negedge clk);
        chk("A_done_once", done_cnt[0], 1);

        // long read from requester 1
        @(posedge clk); #3;
        resp_data = 8'h5C;
        set_slot(1, 2'b10, 10'h200, 8'h00);
        req[1] = 1'b1;
        wait_done(1, 1, 40);
        chk("B_done", done_o, 3'b010);
        chk("B_rdata", rdata_o, 8'h5C);
        @(posedge clk); #3 rf_rdata = 8'hEE;
        repeat (4) @(negedge clk);
        chk("B_rdata_hold", rdata_o, 8'h5C);

        // 0+2 together with ptr at 2, then again with ptr at 1
        @(posedge clk); #3;
        set_slot(0, 2'b00, 10'h010, 8'h00);
        set_slot(2, 2'b11, 10'h3FF, 8'h3C);
        g0 = gq.size();
        req = 3'b101;
        wait_done(0, 2, 80);
        chk("C1_first", gq[g0], 2);
        chk("C1_second", gq[g0+1], 0);
        @(posedge clk); #3;
        resp_data = 8'h77;
        g0 = gq.size();
        req = 3'b101;
        wait_done(0, 3, 80);
        chk("C2_first", gq[g0], 2);
        chk("C2_second", gq[g0+1], 0);
        chk("C2_rdata", rdata_o, 8'h77);

        // reset during SETTLE aborts; pending req[1] regranted from ptr 0
        @(posedge clk); #3;
        set_slot(1, 2'b01, 10'h155, 8'h99);
        n = cs_cyc.size();
        d1 = done_cnt[1];
        req[1] = 1'b1;
        wait_cs(n + 1, 20);
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk); #1;
        chk("D_rst_gnt", gnt_o, 0);
        chk("D_rst_addr", rf_addr_o, 0);
        chk("D_rst_rdata", rdata_o, 0);
        @(posedge clk); #3 rst = 1'b0;
        g0 = gq.size();
        wait_grants(g0 + 1, 10);
        chk("D_regrant", gq[g0], 1);
        chk("D_abort_no_done", done_cnt[1], d1);
        wait_done(1, d1 + 1, 40);

        // fresh reset: 0+2 at ptr 0 grants 0 then 2
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
        g0 = gq.size();
        req = 3'b101;
        wait_done(2, 3, 80);
        chk("E_first", gq[g0], 0);
        chk("E_second", gq[g0+1], 2);

        // all three held for nine transactions
        hold = 1'b1;
        @(posedge clk); #3;
        g0 = gq.size();
        req = 3'b111;
        wait_grants(g0 + 9, 250);
        @(posedge clk); #3 req = '0;
        hold = 1'b0;
        wait_done(2, 6, 60);
        for (int k = 0; k < 9; k++) chk("F_order", gq[g0+k], k % 3);
        for (int k = 1; k < 9; k++) chk("F_no_repeat", (gq[g0+k] != gq[g0+k-1]) ? 1 : 0, 1);

        // ready never returns
        hang = 1'b1;
        @(posedge clk); #3;
        set_slot(0, 2'b01, 10'h2AA, 8'h5A);
        d0 = done_cnt[0];
        req[0] = 1'b1;
`ifdef RF_ARB_TIMEOUT_EN
        wait_done(0, d0 + 1, 4300);
        chk("G_err", last_err, 3'b001);
        chk("G_rdata", rdata_o, 0);
        chk("G_lat", done_cyc - gnt_cyc, 4102);
`else
        repeat (60) @(negedge clk);
        chk("G_gnt_held", gnt_o, 3'b001);
        chk("G_no_done", done_cnt[0], d0);
        chk("G_err_zero", err_o, 0);
`endif
        @(posedge clk); #3 rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
